// File: rtl/regfile_mp_pkg.sv
// Shared constants, state encoding and width helpers for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_CLEAR = 1'b1
  } clr_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A single-entry file still needs one address bit to keep port widths legal.
  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode stage (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int DEPTH  = regfile_pkg::DEPTH_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = regfile_pkg::addr_w(DEPTH);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_pend, clr_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output rd_data, rd_pend, clr_busy
  );

endinterface

// File: rtl/regfile_mp_clr_fsm.sv
// Soft-clear sequencer: walks every register address once, one per cycle.
//   state       | meaning
//   STATE_IDLE  | waiting for clr_req; file accepts writes and reserves
//   STATE_CLEAR | zeroing reg[cnt]/pend[cnt] each cycle; clr_busy high
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // One extra bit so the terminal compare never aliases for non power-of-2 depths.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  clr_state_t  state;
  logic [AW:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= STATE_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (clr_req) begin
            state    <= STATE_CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        STATE_CLEAR: begin
          if (cnt == CNT_LAST) begin
            state    <= STATE_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= STATE_IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = clr_busy;
  assign clr_addr = cnt[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, same-cycle bypass, pending-write scoreboard
// and a sequenced soft clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);

  localparam int          AW      = addr_w(DEPTH);
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         pend;

  logic                     clr_busy;
  logic                     clr_we;
  logic [AW-1:0]            clr_addr;

  logic [AW-1:0]            wa [NUM_WR];
  logic [DATA_W-1:0]        wd [NUM_WR];
  logic [NUM_WR-1:0]        wv;
  logic                     rsv_ok;

  logic [AW-1:0]            ra [NUM_RD];
  logic [NUM_RD-1:0]        hit;
  logic [DATA_W-1:0]        rdv [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_v;
  logic [NUM_RD-1:0]        rd_pend_v;

  // An address that maps onto real storage (in range, and not the hardwired zero register).
  function automatic logic live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  regfile_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = bus.wr_addr[j*AW +: AW];
      wd[j] = bus.wr_data[j*DATA_W +: DATA_W];
      wv[j] = bus.wr_en[j] && !clr_busy && live(wa[j]);
    end
    rsv_ok = bus.rsv_en && !clr_busy && live(bus.rsv_addr);
  end

  // Later j overrides earlier j, giving the highest write port priority on bypass.
  always_comb begin
    rd_data_v = '0;
    rd_pend_v = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra[k]  = bus.rd_addr[k*AW +: AW];
      rdv[k] = live(ra[k]) ? mem[ra[k]] : '0;
      hit[k] = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wv[j] && (wa[j] == ra[k])) begin
            hit[k] = 1'b1;
            rdv[k] = wd[j];
          end
        end
      end
      rd_data_v[k*DATA_W +: DATA_W] = rdv[k];
      rd_pend_v[k] = (live(ra[k]) ? pend[ra[k]] : 1'b0) & ~hit[k];
    end
  end

  assign bus.rd_data  = rd_data_v;
  assign bus.rd_pend  = rd_pend_v;
  assign bus.clr_busy = clr_busy;

  // Reserve is applied after the writes so a newly issued producer keeps its pending bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else if (clr_we) begin
      mem[clr_addr]  <= '0;
      pend[clr_addr] <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wv[j]) begin
          mem[wa[j]]  <= wd[j];
          pend[wa[j]] <= 1'b0;
        end
      end
      if (rsv_ok) pend[bus.rsv_addr] <= 1'b1;
    end
  end

endmodule
